// File: rtl/stoch_const_gen.sv
// stoch_const_gen: multi-channel programmable stochastic constant generator sharing one LFSR
module stoch_const_gen #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int SEED = 1,
  parameter int ROT_STEP = 3,
  parameter int INIT_PROB = 0,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                en,
  input  logic                restart,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [CW-1:0]       load_ch,
  input  logic [WIDTH-1:0]    load_value,
  output logic [CHANNELS-1:0] y,
  output logic                frame_start
);
  localparam logic [15:0] TAPS16 = WIDTH == 8  ? 16'h00B8 :
                                   WIDTH == 10 ? 16'h0240 :
                                   WIDTH == 12 ? 16'h0829 : 16'hB400;
  localparam logic [WIDTH-1:0] TAPS = TAPS16[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LAST = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_PROB);
  if (!(WIDTH inside {8, 10, 12, 16})) begin : g_bad_width
    $error("stoch_const_gen: WIDTH must be 8, 10, 12 or 16");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("stoch_const_gen: CHANNELS must be 1..16");
  end
  if (SEED < 1 || SEED >= 2**WIDTH) begin : g_bad_seed
    $error("stoch_const_gen: SEED must be nonzero and fit in WIDTH bits");
  end
  if (INIT_PROB < 0 || INIT_PROB >= 2**WIDTH) begin : g_bad_init
    $error("stoch_const_gen: INIT_PROB must be 0..2^WIDTH-1");
  end
  logic [WIDTH-1:0]    lfsr;
  logic [WIDTH-1:0]    cnt;
  logic [CHANNELS-1:0] bit_nxt;
  logic [CHANNELS-1:0] pend;
  logic                frame_end;
  logic                apply;
  logic                in_range;
  logic                acc;
  assign frame_end = en && cnt == LAST;
  assign apply = restart || frame_end;
  assign in_range = {1'b0, load_ch} < (CW+1)'(CHANNELS);
  // a pending channel reopens on the applying cycle so the write bypasses into active
  assign load_ready = !in_range || !pend[load_ch] || apply;
  assign acc = load_valid && load_ready;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam int R = (c * ROT_STEP) % WIDTH;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] rot;
    logic             pending;
    logic             wr;
    assign rot = WIDTH'({lfsr, lfsr} >> (WIDTH - R));
    assign bit_nxt[c] = rot <= active;
    assign pend[c] = pending;
    assign wr = acc && load_ch == CW'(c);
    always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
        active <= INIT_V;
        shadow <= INIT_V;
        pending <= 1'b0;
      end else if (apply) begin
        active <= wr ? load_value : pending ? shadow : active;
        shadow <= wr ? load_value : shadow;
        pending <= 1'b0;
      end else if (wr) begin
        shadow <= load_value;
        pending <= 1'b1;
      end
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      lfsr <= SEED_V;
      cnt <= '0;
      y <= '0;
      frame_start <= 1'b0;
    end else if (restart) begin
      lfsr <= SEED_V;
      cnt <= '0;
      y <= '0;
      frame_start <= 1'b0;
    end else if (en) begin
      y <= bit_nxt;
      frame_start <= cnt == '0;
      lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
      cnt <= frame_end ? '0 : cnt + 1'b1;
    end
endmodule

// File: tb/tb_stoch_const_gen.sv
// tb_stoch_const_gen: scoreboard bench; expected per-frame ones counts queued by stimulus, checked by monitors
module tb_stoch_const_gen;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;
  logic       en = 1'b0, restart = 1'b0, load_valid = 1'b0, load_ready;
  logic [1:0] load_ch = 2'd0;
  logic [7:0] load_value = 8'd0;
  logic [3:0] y;
  logic       frame_start;
  logic       en1 = 1'b0, restart1 = 1'b0, load_valid1 = 1'b0, load_ready1;
  logic       load_ch1 = 1'b0;
  logic [9:0] load_value1 = 10'd0;
  logic [1:0] y1;
  logic       fs1;
  stoch_const_gen u0 (
    .clk(clk), .n_rst(n_rst), .en(en), .restart(restart), .load_valid(load_valid),
    .load_ready(load_ready), .load_ch(load_ch), .load_value(load_value), .y(y),
    .frame_start(frame_start)
  );
  stoch_const_gen #(.WIDTH(10), .CHANNELS(2)) u1 (
    .clk(clk), .n_rst(n_rst), .en(en1), .restart(restart1), .load_valid(load_valid1),
    .load_ready(load_ready1), .load_ch(load_ch1), .load_value(load_value1), .y(y1),
    .frame_start(fs1)
  );
  int checks = 0;
  int errors = 0;
  typedef logic [3:0][8:0] exp_t;
  exp_t q[$];
  int   q1[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [7:0] step8(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction
  function automatic logic [7:0] rot8(input logic [7:0] x, input int r);
    return (x << r) | (x >> (8 - r));
  endfunction
  // monitor for the 8-bit, 4-channel instance
  logic [3:0] y_prev = '0;
  logic       fs_prev = 1'b0;
  int         nbits = 0;
  int         ones [4];
  bit         in_frame = 0, expect_fs = 0;
  exp_t       e;
  initial forever begin
    logic en_s, rs_s;
    @(posedge clk);
    en_s = en;
    rs_s = restart;
    #1;
    if (!n_rst || rs_s) begin
      in_frame = 0;
      expect_fs = 0;
    end else if (en_s) begin
      if (expect_fs) chk("fs_period", frame_start, 1);
      expect_fs = 0;
      if (frame_start) begin
        if (in_frame) chk("frame_len", nbits, 255);
        in_frame = 1;
        nbits = 1;
        for (int c = 0; c < 4; c++) ones[c] = int'(y[c]);
      end else if (in_frame) begin
        nbits++;
        for (int c = 0; c < 4; c++) ones[c] += int'(y[c]);
      end
      if (in_frame && nbits == 255) begin
        in_frame = 0;
        expect_fs = 1;
        if (q.size() > 0) begin
          e = q.pop_front();
          for (int c = 0; c < 4; c++) chk($sformatf("ones_ch%0d", c), ones[c], 32'(e[c]));
        end
      end
    end else begin
      chk("hold_en0", {y, frame_start}, {y_prev, fs_prev});
    end
    y_prev = y;
    fs_prev = frame_start;
  end
  // monitor for the 10-bit, 2-channel instance
  int nb1 = 0, and1 = 0, diff1 = 0, ev1 = 0;
  int o1 [2];
  bit in1 = 0;
  initial forever begin
    logic e_s;
    @(posedge clk);
    e_s = en1 && !restart1 && n_rst;
    #1;
    if (e_s) begin
      if (fs1) begin
        in1 = 1;
        nb1 = 1;
        o1[0] = int'(y1[0]);
        o1[1] = int'(y1[1]);
        and1 = int'(y1[0] & y1[1]);
        diff1 = int'(y1[0] ^ y1[1]);
      end else if (in1) begin
        nb1++;
        o1[0] += int'(y1[0]);
        o1[1] += int'(y1[1]);
        and1 += int'(y1[0] & y1[1]);
        diff1 += int'(y1[0] ^ y1[1]);
      end
      if (in1 && nb1 == 1023) begin
        in1 = 0;
        if (q1.size() > 0) begin
          ev1 = q1.pop_front();
          chk("w10_ones_ch0", o1[0], ev1);
          chk("w10_ones_ch1", o1[1], ev1);
          chk("w10_and_near_255", and1 >= 215 && and1 <= 295, 1);
          chk("w10_streams_differ", diff1 != 0, 1);
        end
      end
    end
  end
  task automatic wait_cnt(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(u0.cnt) != k && n < 3000);
    if (int'(u0.cnt) != k) chk("wait_cnt_timeout", u0.cnt, k);
  endtask
  task automatic wait_q(input int maxc);
    int n = 0;
    while (q.size() > 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      chk("scoreboard_drain", q.size(), 0);
      q.delete();
    end
  endtask
  task automatic load(input logic [1:0] ch, input logic [7:0] v, output int waited, output int at_cnt);
    waited = 0;
    @(negedge clk);
    load_valid = 1'b1;
    load_ch = ch;
    load_value = v;
    #1;
    while (!load_ready && waited < 1000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    at_cnt = int'(u0.cnt);
    if (!load_ready) chk("load_timeout", load_ready, 1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask
  initial begin
    int w, at, n;
    logic [7:0] m;
    logic [3:0] ey;
    int p [4] = '{0, 200, 30, 255};
    int r [4] = '{0, 3, 6, 1};
    repeat (3) @(negedge clk);
    chk("rst_y", y, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_lfsr", u0.lfsr, 1);
    chk("rst_ready", load_ready, 1);
    n_rst = 1'b1;
    load(2'd0, 8'd0, w, at);
    load(2'd1, 8'd64, w, at);
    load(2'd2, 8'd128, w, at);
    load(2'd3, 8'd255, w, at);
    chk("pending_before_apply", u0.g_ch[3].pending, 1);
    @(negedge clk);
    load_ch = 2'd3;
    #1 chk("ready_low_pending", load_ready, 0);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_applies", u0.g_ch[2].active, 128);
    q.push_back({9'd255, 9'd128, 9'd64, 9'd0});
    q.push_back({9'd255, 9'd128, 9'd64, 9'd0});
    en = 1'b1;
    wait_q(700);
    wait_cnt(100);
    load(2'd1, 8'd200, w, at);
    chk("midframe_pending", u0.g_ch[1].pending, 1);
    q.push_back({9'd255, 9'd128, 9'd64, 9'd0});
    q.push_back({9'd255, 9'd128, 9'd200, 9'd0});
    wait_cnt(0);
    chk("pending_cleared", u0.g_ch[1].pending, 0);
    wait_cnt(50);
    load(2'd2, 8'd10, w, at);
    chk("bp_first_no_wait", w, 0);
    load(2'd2, 8'd30, w, at);
    chk("bp_stalled", w > 0, 1);
    chk("bp_accept_cnt", at, 254);
    chk("bp_bypass_pending", u0.g_ch[2].pending, 0);
    chk("bp_bypass_active", u0.g_ch[2].active, 30);
    q.push_back({9'd255, 9'd30, 9'd200, 9'd0});
    q.push_back({9'd255, 9'd30, 9'd200, 9'd0});
    q.push_back({9'd255, 9'd30, 9'd200, 9'd0});
    n = 0;
    while (q.size() > 0 && n < 3000) begin
      @(negedge clk);
      en = $urandom_range(0, 3) != 0;
      n++;
    end
    wait_q(1);
    @(negedge clk);
    en = 1'b1;
    wait_cnt(37);
    restart = 1'b1;
    @(posedge clk);
    #1;
    chk("rs_y0", y, 0);
    chk("rs_fs0", frame_start, 0);
    chk("rs_lfsr", u0.lfsr, 1);
    chk("rs_cnt", u0.cnt, 0);
    @(negedge clk);
    restart = 1'b0;
    q.push_back({9'd255, 9'd30, 9'd200, 9'd0});
    m = 8'd1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) ey[c] = int'(rot8(m, r[c])) <= p[c];
      chk("rs_fs_seq", frame_start, k == 0);
      chk("rs_y_seq", y, ey);
      m = step8(m);
      chk("rs_lfsr_seq", u0.lfsr, m);
    end
    wait_q(600);
    load(2'd3, 8'd77, w, at);
    wait_cnt(150);
    chk("pre_reset_y3", y[3], 1);
    n_rst = 1'b0;
    #1;
    chk("arst_y", y, 0);
    chk("arst_fs", frame_start, 0);
    chk("arst_pending", {u0.g_ch[3].pending, u0.g_ch[2].pending, u0.g_ch[1].pending, u0.g_ch[0].pending}, 0);
    chk("arst_active", {u0.g_ch[3].active, u0.g_ch[2].active, u0.g_ch[1].active, u0.g_ch[0].active}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    q.push_back({9'd0, 9'd0, 9'd0, 9'd0});
    wait_q(600);
    @(negedge clk);
    load_valid1 = 1'b1;
    load_ch1 = 1'b0;
    load_value1 = 10'd511;
    #1 chk("w10_ready_ch0", load_ready1, 1);
    @(posedge clk);
    #1;
    load_ch1 = 1'b1;
    #1 chk("w10_ready_ch1", load_ready1, 1);
    @(posedge clk);
    #1;
    load_valid1 = 1'b0;
    @(negedge clk);
    restart1 = 1'b1;
    @(negedge clk);
    restart1 = 1'b0;
    q1.push_back(511);
    en1 = 1'b1;
    n = 0;
    while (q1.size() > 0 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() > 0) chk("w10_drain", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
